// File: rtl/conf_int_add_operand_stage_if.sv
// Valid/ready operand-pair channel. The master drives the pair and valid;
// the slave answers with ready. One instance sits on each side of the
// operand stage.
interface conf_int_add_operand_stage_if #(
    parameter int DATA_PATH_BITWIDTH = 16
);
    logic                          valid;
    logic                          ready;
    logic [DATA_PATH_BITWIDTH-1:0] a;
    logic [DATA_PATH_BITWIDTH-1:0] b;

    modport master (output valid, output a, output b, input ready);
    modport slave  (input valid, input a, input b, output ready);
endinterface

// File: rtl/conf_int_add_operand_stage.sv
// Registered operand-issue stage in front of the flop-less integer adder.
// A 2-entry skid FIFO (head + skid register) buffers operand pairs, masks
// off the operand LSBs below the effective precision on capture, and
// presents the head pair to the adder. in_ready/out_valid come only from
// registered state, so no combinational path crosses the stage.
module conf_int_add_operand_stage #(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,        // active-low, asynchronous
    conf_int_add_operand_stage_if.slave   in_if,      // producer side
    conf_int_add_operand_stage_if.master  out_if,     // adder side
    output logic [1:0]                    occupancy,
    output logic [CNT_WIDTH-1:0]          issue_cnt
);

    localparam int DW        = DATA_PATH_BITWIDTH;
    localparam int MASK_BITS = (OP_BITWIDTH < DATA_PATH_BITWIDTH) ?
                               (DATA_PATH_BITWIDTH - OP_BITWIDTH) : 0;

    // Registered state doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]           r_state;
    logic                 r_init;      // low until the first edge after reset release
    logic [DW-1:0]        r_head_a;
    logic [DW-1:0]        r_head_b;
    logic [DW-1:0]        r_skid_a;
    logic [DW-1:0]        r_skid_b;
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [DW-1:0]        w_mask;
    logic [DW-1:0]        w_in_a_masked;
    logic [DW-1:0]        w_in_b_masked;
    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_state_next;
    logic                 w_head_load_new;
    logic                 w_head_load_skid;
    logic                 w_skid_load;

    // Reduced-precision mask: bits below the effective precision are zero.
    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_mask
            assign w_mask[gi] = (gi >= MASK_BITS) ? 1'b1 : 1'b0;
        end
    endgenerate

    assign w_in_a_masked = in_if.a & w_mask;
    assign w_in_b_masked = in_if.b & w_mask;

    assign w_in_ready  = r_init & (r_state != ST_FULL);
    assign w_out_valid = (r_state == ST_ONE) | (r_state == ST_FULL);
    assign w_push      = in_if.valid & w_in_ready;
    assign w_pop       = w_out_valid & out_if.ready;

    assign in_if.ready  = w_in_ready;
    assign out_if.valid = w_out_valid;
    assign out_if.a     = r_head_a;
    assign out_if.b     = r_head_b;
    assign occupancy    = r_state;
    assign issue_cnt    = r_cnt;

    // Next-state and register-load decode for the head/skid pair.
    always_comb begin
        w_state_next     = r_state;
        w_head_load_new  = 1'b0;
        w_head_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                // No bypass: a pushed pair appears on the outputs next cycle.
                if (w_push) begin
                    w_state_next    = ST_ONE;
                    w_head_load_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_head_load_new = 1'b1;
                end else if (w_push) begin
                    w_state_next = ST_FULL;
                    w_skid_load  = 1'b1;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_next     = ST_ONE;
                    w_head_load_skid = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    // FSM state and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_init  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_init  <= 1'b1;
        end
    end

    // Head and skid operand registers; head holds its last pair when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_a <= '0;
            r_head_b <= '0;
            r_skid_a <= '0;
            r_skid_b <= '0;
        end else begin
            if (w_head_load_new) begin
                r_head_a <= w_in_a_masked;
                r_head_b <= w_in_b_masked;
            end else if (w_head_load_skid) begin
                r_head_a <= r_skid_a;
                r_head_b <= r_skid_b;
            end
            if (w_skid_load) begin
                r_skid_a <= w_in_a_masked;
                r_skid_b <= w_in_b_masked;
            end
        end
    end

    // Count completed output handshakes; wraps silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
